if_prefetch: RTL

Parametrised next-generation instruction fetch stage with a DEPTH-entry prefetch queue between the memory arbiter and decode. It fetches sequentially ahead of decode, keeping at most one arbiter request outstanding. Redirects (reset-PC, branch, jump) flush the queue and discard any in-flight return. Decode consumes through a valid/ready handshake, and each instruction carries its PC.

---
 rtl/if_prefetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction prefetcher feeding decode through a DEPTH-entry queue,
// one outstanding arbiter request, and redirect flush with in-flight discard.
module if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pc_reset_i,
  input  logic                    is_branch_i,
  input  logic [ADDR_W-1:0]       branch_addr_i,
  input  logic                    is_jump_i,
  input  logic [ADDR_W-1:0]       jump_addr_i,
  output logic                    read_req_o,
  input  logic                    read_ack_i,
  output logic [ADDR_W-1:0]       read_addr_o,
  input  logic [DATA_W-1:0]       read_data_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [DATA_W-1:0]       instruction_o,
  output logic [ADDR_W-1:0]       instr_pc_o,
  output logic [ADDR_W-1:0]       pc_next_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d, addr_q, addr_d, target, fpc_inc;
  logic req_q, req_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_pop;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic redirect, valid, pop, push;
  assign redirect = pc_reset_i | is_branch_i | is_jump_i;
  assign target = pc_reset_i ? RESET_PC : is_branch_i ? branch_addr_i : jump_addr_i;
  assign valid = cnt_q != '0;
  assign pop = valid & instr_ready_i;
  assign push = (state_q == REQ) & read_ack_i & ~redirect;
  assign fpc_inc = fpc_q + STEP;
  assign cnt_pop = cnt_q - CW'(pop);
  always_comb begin
    state_d = state_q;
    fpc_d = fpc_q;
    addr_d = addr_q;
    req_d = req_q;
    rd_d = rd_q + PW'(pop);
    wr_d = wr_q + PW'(push);
    cnt_d = cnt_pop + CW'(push);
    if (redirect) begin
      fpc_d = target;
      rd_d = '0;
      wr_d = '0;
      cnt_d = '0;
      // An unacked request cannot be withdrawn, so it is kept alive and its data discarded
      state_d = state_q == IDLE ? REQ : read_ack_i ? IDLE : DISCARD;
      req_d = state_q == IDLE | ~read_ack_i;
      addr_d = state_q == IDLE ? target : addr_q;
    end else if (state_q == IDLE) begin
      req_d = cnt_pop < CW'(DEPTH);
      state_d = req_d ? REQ : IDLE;
      addr_d = req_d ? fpc_q : addr_q;
    end else if (read_ack_i) begin
      fpc_d = state_q == REQ ? fpc_inc : fpc_q;
      req_d = state_q == REQ && cnt_d < CW'(DEPTH);
      state_d = req_d ? REQ : IDLE;
      addr_d = req_d ? fpc_inc : addr_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
      addr_q <= RESET_PC;
      req_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      addr_q <= addr_d;
      req_q <= req_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q] <= read_data_i;
      pc_mem[wr_q] <= fpc_q;
    end
  end
  assign read_req_o = req_q;
  assign read_addr_o = addr_q;
  assign count_o = cnt_q;
  assign instr_valid_o = valid;
  assign instruction_o = valid ? data_mem[rd_q] : '0;
  assign instr_pc_o = valid ? pc_mem[rd_q] : '0;
  assign pc_next_o = valid ? pc_mem[rd_q] + STEP : '0;
endmodule
